matmul_out_writeback: RTL and testbench
=======================================

Name: matmul_out_writeback

Overview:
Output-side collector for the weight-stationary systolic matmul datapath.
- Captures the per-column bottom_out results of the array into a ROWS x COLS result buffer.
- Substitutes weight-proxy results for any column whose proxy reports a valid output.
- Writes the completed matrix row by row to the output RAM, stalling the array and FSM while doing so.

Parameters:
ROWS, 4, systolic array rows (= result rows)
COLS, 4, systolic array columns
WORD_SIZE, 16, bits per result word
MEM_ACCESS_LATENCY, 1, cycles per output-RAM write (>=1)
MEM_PORT_WIDTH, COLS*WORD_SIZE, output RAM data width
OUT_BASE_ADDR, 0, address of result row 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  out  1  freezes array and matmul FSM while writing
fsm_rdy  in  1  matmul FSM idle/ready; clears capture state
fsm_done  in  1  matmul FSM finished feeding the array
matmul_fsm_output  in  COLS*WORD_SIZE  array bottom_out; column c at [c*WORD_SIZE +: WORD_SIZE]
matmul_output_valid  in  COLS  per-column valid for matmul_fsm_output
proxy_output_bus  in  COLS*WORD_SIZE  proxy result per column, same packing
proxy_out_valid_bus  in  COLS  per-column proxy valid; tie 0 when proxy unused
wr_output_rdy  out  1  buffer complete, write-back in progress
wr_output_done  out  1  one-cycle pulse after the last row is written
mem_addr  out  32  output RAM address
mem_wr_en  out  1  output RAM write strobe
mem_data  out  MEM_PORT_WIDTH  output RAM write data

Behaviour:
- Reset (rst=0, async):
  - state=COLLECT; all column counters and buffer words cleared to 0.
  - All outputs 0; mem_addr=OUT_BASE_ADDR.
- COLLECT, per column c, each cycle with stall=0:
  - Proxy priority: if proxy_out_valid_bus[c] and cnt[c]<ROWS, buf[cnt[c]][c] <= proxy word and cnt[c]++.
  - Otherwise, if matmul_output_valid[c] and cnt[c]<ROWS, capture the matmul word the same way.
  - Words arriving with cnt[c]==ROWS are dropped.
- Transition to WRITE on:
  - all cnt[c]==ROWS, evaluated after the current cycle's captures; or
  - fsm_done=1 with any cnt>0. Unfilled words remain 0.
- fsm_rdy=1 in COLLECT clears all counters and the buffer. Captures in that same cycle are discarded.
- WRITE:
  - stall=1 and wr_output_rdy=1 for the whole state.
  - Row r (0..ROWS-1), first cycle: mem_wr_en=1, mem_addr=OUT_BASE_ADDR+r, mem_data = row r with column 0 in the LSBs.
  - Then MEM_ACCESS_LATENCY-1 cycles with mem_wr_en=0 and addr/data held.
  - Latency 1 gives ROWS back-to-back write cycles.
  - Inputs are ignored during WRITE.
- DONE (one cycle):
  - wr_output_done=1, stall=0, wr_output_rdy=0, mem_wr_en=0.
  - Counters and buffer cleared; next state is COLLECT.
- Total write-back time = ROWS*MEM_ACCESS_LATENCY cycles, plus 1 DONE cycle.
- Reset asserted mid-WRITE aborts immediately: no further writes, no done pulse.
- mem_data is zero-padded when MEM_PORT_WIDTH > COLS*WORD_SIZE.
- No arithmetic: words are stored verbatim, no truncation.

Decomposition:
- Shared package `matmul_out_pkg`:
  - state enum {COLLECT, WRITE, DONE}
  - counter width $clog2(ROWS+1)
  - latency-counter width
- One natural sub-module, `out_col_capture`:
  - one instance per column (generate)
  - owns cnt[c], proxy/matmul select and the ROWS-word column storage
  - exposes a full flag and per-row word read
- Top holds the FSM, row index, latency counter and memory port.

Test Plan:
- 4x4, latency 1:
  - Stimulus: column c presents valid words 10*r+c on four skewed cycles (column c starts at cycle c).
  - Response: after the last capture, wr_output_rdy=1 and stall=1; four consecutive writes to addrs 0..3 with row r = {30+r? no: 10r+3, 10r+2, 10r+1, 10r}, MSB to LSB; then one wr_output_done pulse.
- Proxy substitution:
  - Stimulus: column 2 has both valids high with matmul=0xDEAD and proxy=0x0042.
  - Response: column 2 of every row = 0x0042.
- MEM_ACCESS_LATENCY=3:
  - Response: mem_wr_en high on cycles 0, 3, 6, 9 of WRITE; stall high for 12 cycles; done pulse on cycle 12.
- Early fsm_done:
  - Stimulus: only rows 0-1 captured, then fsm_done=1.
  - Response: four writes; rows 2-3 are all zeros.
- Overflow: a fifth valid word on column 0 is ignored; buffer contents unchanged.
- Reset during WRITE:
  - Stimulus: rst=0 after the second write.
  - Response: all outputs 0 immediately; no writes to addrs 2-3 and no wr_output_done.

Source files
------------

// File: rtl/matmul_out_pkg.sv
// Shared FSM encodings and width helpers for the matmul output write-back block.
package matmul_out_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  function automatic int cnt_w(input int rows);
    return $clog2(rows + 1);
  endfunction

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int lat_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/matmul_out_writeback_if.sv
// Array-side capture inputs, FSM handshake and output-RAM write port of the write-back block.
interface matmul_out_writeback_if #(
  parameter int COLS           = 4,
  parameter int WORD_SIZE      = 16,
  parameter int MEM_PORT_WIDTH = COLS * WORD_SIZE
);
  logic                      stall;
  logic                      fsm_rdy;
  logic                      fsm_done;
  logic [COLS*WORD_SIZE-1:0] matmul_fsm_output;
  logic [COLS-1:0]           matmul_output_valid;
  logic [COLS*WORD_SIZE-1:0] proxy_output_bus;
  logic [COLS-1:0]           proxy_out_valid_bus;
  logic                      wr_output_rdy;
  logic                      wr_output_done;
  logic [31:0]               mem_addr;
  logic                      mem_wr_en;
  logic [MEM_PORT_WIDTH-1:0] mem_data;

  modport master (
    output stall, wr_output_rdy, wr_output_done, mem_addr, mem_wr_en, mem_data,
    input  fsm_rdy, fsm_done, matmul_fsm_output, matmul_output_valid,
           proxy_output_bus, proxy_out_valid_bus
  );

  modport slave (
    input  stall, wr_output_rdy, wr_output_done, mem_addr, mem_wr_en, mem_data,
    output fsm_rdy, fsm_done, matmul_fsm_output, matmul_output_valid,
           proxy_output_bus, proxy_out_valid_bus
  );
endinterface

// File: rtl/matmul_out_writeback_col_capture.sv
// One result column: fill counter, proxy-over-matmul select and ROWS-deep word storage.
module out_col_capture
  import matmul_out_pkg::*;
#(
  parameter int  ROWS      = 4,
  parameter int  WORD_SIZE = 16,
  localparam int CW        = cnt_w(ROWS),
  localparam int RW        = row_w(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic                 proxy_vld_i,
  input  logic [WORD_SIZE-1:0] proxy_word_i,
  input  logic                 mm_vld_i,
  input  logic [WORD_SIZE-1:0] mm_word_i,
  input  logic [RW-1:0]        rd_row_i,
  output logic                 full_next_o,
  output logic                 nz_next_o,
  output logic [WORD_SIZE-1:0] rd_word_o
);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] words_q [ROWS];
  logic                 wr_s;
  logic [WORD_SIZE-1:0] wr_word_s;
  logic                 has_room_s;

  assign has_room_s = (cnt_q < CW'(ROWS));

  // Capture select and next fill count; a clear overrides any same-cycle capture.
  always_comb begin
    wr_s      = 1'b0;
    wr_word_s = '0;
    cnt_d     = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && has_room_s) begin
      if (proxy_vld_i) begin
        wr_s      = 1'b1;
        wr_word_s = proxy_word_i;
      end else if (mm_vld_i) begin
        wr_s      = 1'b1;
        wr_word_s = mm_word_i;
      end else begin
        wr_s = 1'b0;
      end
      cnt_d = cnt_q + CW'(wr_s);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and column storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      words_q <= '{default: '0};
    end else if (clear_i) begin
      cnt_q   <= '0;
      words_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      if (wr_s) begin
        words_q[cnt_q[RW-1:0]] <= wr_word_s;
      end
    end
  end

  assign full_next_o = (cnt_d == CW'(ROWS));
  assign nz_next_o   = |cnt_d;
  assign rd_word_o   = words_q[rd_row_i];

endmodule

// File: rtl/matmul_out_writeback.sv
// Collects systolic-array column results into a ROWS x COLS buffer and writes it row by row to the output RAM.
module matmul_out_writeback
  import matmul_out_pkg::*;
#(
  parameter int          ROWS               = 4,
  parameter int          COLS               = 4,
  parameter int          WORD_SIZE          = 16,
  parameter int          MEM_ACCESS_LATENCY = 1,
  parameter int          MEM_PORT_WIDTH     = COLS * WORD_SIZE,
  parameter logic [31:0] OUT_BASE_ADDR      = 32'd0
) (
  input logic                    clk,
  input logic                    rst,
  matmul_out_writeback_if.master bus
);

  localparam int RW = row_w(ROWS);
  localparam int LW = lat_w(MEM_ACCESS_LATENCY);
  localparam int DW = COLS * WORD_SIZE;

  logic [1:0]           state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [LW-1:0]        lat_q, lat_d;
  logic                 stall_q, stall_d;
  logic                 rdy_q, rdy_d;
  logic                 done_q, done_d;
  logic                 wr_en_q, wr_en_d;
  logic [31:0]          addr_q, addr_d;
  logic [COLS-1:0]      full_next_s, nz_next_s;
  logic [WORD_SIZE-1:0] col_word_s [COLS];
  logic [DW-1:0]        row_data_s;
  logic                 collect_s, clear_s, go_s;

  assign collect_s = (state_q == ST_COLLECT);
  assign clear_s   = (collect_s && bus.fsm_rdy) || (state_q == ST_DONE);
  // Column next-state flags already include this cycle's captures (and any clear).
  assign go_s      = collect_s && ((&full_next_s) || (bus.fsm_done && (|nz_next_s)));

  for (genvar c = 0; c < COLS; c++) begin : g_col
    out_col_capture #(
      .ROWS      (ROWS),
      .WORD_SIZE (WORD_SIZE)
    ) u_col (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (clear_s),
      .en_i         (collect_s),
      .proxy_vld_i  (bus.proxy_out_valid_bus[c]),
      .proxy_word_i (bus.proxy_output_bus[c*WORD_SIZE +: WORD_SIZE]),
      .mm_vld_i     (bus.matmul_output_valid[c]),
      .mm_word_i    (bus.matmul_fsm_output[c*WORD_SIZE +: WORD_SIZE]),
      .rd_row_i     (row_q),
      .full_next_o  (full_next_s[c]),
      .nz_next_o    (nz_next_s[c]),
      .rd_word_o    (col_word_s[c])
    );
    assign row_data_s[c*WORD_SIZE +: WORD_SIZE] = col_word_s[c];
  end

  // FSM next state and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    lat_d   = lat_q;
    stall_d = stall_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      ST_COLLECT: begin
        if (go_s) begin
          state_d = ST_WRITE;
          row_d   = '0;
          lat_d   = '0;
          stall_d = 1'b1;
          rdy_d   = 1'b1;
          wr_en_d = 1'b1;
          addr_d  = OUT_BASE_ADDR;
        end else begin
          stall_d = 1'b0;
          rdy_d   = 1'b0;
          addr_d  = OUT_BASE_ADDR;
        end
      end
      ST_WRITE: begin
        if (lat_q == LW'(MEM_ACCESS_LATENCY - 1)) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = ST_DONE;
            stall_d = 1'b0;
            rdy_d   = 1'b0;
            done_d  = 1'b1;
            addr_d  = OUT_BASE_ADDR;
          end else begin
            row_d   = row_q + 1'b1;
            lat_d   = '0;
            wr_en_d = 1'b1;
            addr_d  = OUT_BASE_ADDR + 32'(row_q) + 32'd1;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_COLLECT;
        stall_d = 1'b0;
        rdy_d   = 1'b0;
        addr_d  = OUT_BASE_ADDR;
      end
    endcase
  end

  // State and output registers; reset aborts any write-back in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_COLLECT;
      row_q   <= '0;
      lat_q   <= '0;
      stall_q <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= OUT_BASE_ADDR;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      lat_q   <= lat_d;
      stall_q <= stall_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.stall          = stall_q;
  assign bus.wr_output_rdy  = rdy_q;
  assign bus.wr_output_done = done_q;
  assign bus.mem_wr_en      = wr_en_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_data       = (state_q == ST_WRITE) ? MEM_PORT_WIDTH'(row_data_s) : '0;

endmodule

// File: tb/tb_matmul_out_writeback.sv
// Directed self-checking bench: latency-1 instance for most scenarios, latency-3 instance for write pacing.
module tb_matmul_out_writeback;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  matmul_out_writeback_if #(.COLS(4), .WORD_SIZE(16)) bus1 ();
  matmul_out_writeback_if #(.COLS(4), .WORD_SIZE(16)) bus3 ();

  matmul_out_writeback #(.MEM_ACCESS_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  matmul_out_writeback #(.MEM_ACCESS_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic idle1();
    bus1.fsm_rdy = 1'b0;
    bus1.fsm_done = 1'b0;
    bus1.matmul_fsm_output = '0;
    bus1.matmul_output_valid = '0;
    bus1.proxy_output_bus = '0;
    bus1.proxy_out_valid_bus = '0;
  endtask

  task automatic idle3();
    bus3.fsm_rdy = 1'b0;
    bus3.fsm_done = 1'b0;
    bus3.matmul_fsm_output = '0;
    bus3.matmul_output_valid = '0;
    bus3.proxy_output_bus = '0;
    bus3.proxy_out_valid_bus = '0;
  endtask

  // Drives one row on all four columns of bus1: word = base + 10*r + c.
  task automatic drive_row1(input int r, input int base);
    @(negedge clk);
    idle1();
    bus1.matmul_output_valid = 4'hF;
    for (int c = 0; c < 4; c++) bus1.matmul_fsm_output[c*16 +: 16] = 16'(base + 10*r + c);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle1();
    idle3();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus1.stall); end
    checks++; if (bus1.wr_output_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", bus1.wr_output_rdy); end
    checks++; if (bus1.wr_output_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus1.wr_output_done); end
    checks++; if (bus1.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus1.mem_wr_en); end
    checks++; if (bus1.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus1.mem_addr); end
    checks++; if (bus1.mem_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus1.mem_data); end
  endtask

  task automatic test_skewed();
    logic [63:0] exp_row;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t == 6) begin
        checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL skew_stall_collect: got %b expected 0", bus1.stall); end
      end
      idle1();
      for (int c = 0; c < 4; c++) begin
        if (t - c >= 0 && t - c < 4) begin
          bus1.matmul_output_valid[c] = 1'b1;
          bus1.matmul_fsm_output[c*16 +: 16] = 16'(10*(t-c) + c);
        end
      end
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      idle1();
      for (int c = 0; c < 4; c++) exp_row[c*16 +: 16] = 16'(10*r + c);
      checks++; if (bus1.mem_wr_en !== 1'b1) begin errors++; $display("FAIL skew_wr_en row %0d: got %b expected 1", r, bus1.mem_wr_en); end
      checks++; if (bus1.mem_addr !== 32'(r)) begin errors++; $display("FAIL skew_addr row %0d: got %h expected %h", r, bus1.mem_addr, r); end
      checks++; if (bus1.mem_data !== exp_row) begin errors++; $display("FAIL skew_data row %0d: got %h expected %h", r, bus1.mem_data, exp_row); end
      checks++; if (bus1.stall !== 1'b1 || bus1.wr_output_rdy !== 1'b1) begin errors++; $display("FAIL skew_stall_rdy row %0d: got %b%b expected 11", r, bus1.stall, bus1.wr_output_rdy); end
    end
    @(negedge clk);
    checks++; if (bus1.wr_output_done !== 1'b1) begin errors++; $display("FAIL skew_done: got %b expected 1", bus1.wr_output_done); end
    checks++; if (bus1.stall !== 1'b0 || bus1.mem_wr_en !== 1'b0 || bus1.wr_output_rdy !== 1'b0) begin errors++; $display("FAIL skew_done_outs: got stall %b wr_en %b rdy %b expected 000", bus1.stall, bus1.mem_wr_en, bus1.wr_output_rdy); end
    @(negedge clk);
    checks++; if (bus1.wr_output_done !== 1'b0) begin errors++; $display("FAIL skew_done_pulse: got %b expected 0", bus1.wr_output_done); end
  endtask

  task automatic test_proxy();
    logic [63:0] exp_row;
    for (int r = 0; r < 4; r++) begin
      drive_row1(r, 0);
      bus1.matmul_fsm_output[2*16 +: 16] = 16'hDEAD;
      bus1.proxy_out_valid_bus = 4'b0100;
      bus1.proxy_output_bus[2*16 +: 16] = 16'h0042;
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      idle1();
      for (int c = 0; c < 4; c++) exp_row[c*16 +: 16] = (c == 2) ? 16'h0042 : 16'(10*r + c);
      checks++; if (bus1.mem_wr_en !== 1'b1 || bus1.mem_data !== exp_row) begin errors++; $display("FAIL proxy_row %0d: got wr_en %b data %h expected 1 %h", r, bus1.mem_wr_en, bus1.mem_data, exp_row); end
    end
    @(negedge clk);
    checks++; if (bus1.wr_output_done !== 1'b1) begin errors++; $display("FAIL proxy_done: got %b expected 1", bus1.wr_output_done); end
  endtask

  task automatic test_early_done();
    logic [63:0] exp_row;
    drive_row1(0, 0);
    drive_row1(1, 0);
    @(negedge clk);
    idle1();
    bus1.fsm_done = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      idle1();
      for (int c = 0; c < 4; c++) exp_row[c*16 +: 16] = (r < 2) ? 16'(10*r + c) : 16'h0000;
      checks++; if (bus1.mem_wr_en !== 1'b1 || bus1.mem_addr !== 32'(r) || bus1.mem_data !== exp_row) begin errors++; $display("FAIL early_row %0d: got wr_en %b addr %h data %h expected 1 %h %h", r, bus1.mem_wr_en, bus1.mem_addr, bus1.mem_data, r, exp_row); end
    end
    @(negedge clk);
    checks++; if (bus1.wr_output_done !== 1'b1) begin errors++; $display("FAIL early_done: got %b expected 1", bus1.wr_output_done); end
  endtask

  task automatic test_overflow();
    logic [63:0] exp_row;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      idle1();
      bus1.matmul_output_valid = 4'b0001;
      bus1.matmul_fsm_output[15:0] = (r < 4) ? 16'(100 + r) : 16'hBEEF;
    end
    for (int r = 0; r < 4; r++) begin
      drive_row1(r, 0);
      bus1.matmul_output_valid = 4'b1110;
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      idle1();
      for (int c = 0; c < 4; c++) exp_row[c*16 +: 16] = (c == 0) ? 16'(100 + r) : 16'(10*r + c);
      checks++; if (bus1.mem_wr_en !== 1'b1 || bus1.mem_data !== exp_row) begin errors++; $display("FAIL overflow_row %0d: got wr_en %b data %h expected 1 %h", r, bus1.mem_wr_en, bus1.mem_data, exp_row); end
    end
    @(negedge clk);
  endtask

  task automatic test_rdy_clear();
    logic [63:0] exp_row;
    drive_row1(0, 16'h0F00);
    drive_row1(1, 16'h0F00);
    drive_row1(2, 16'h0BAD);
    bus1.fsm_rdy = 1'b1;
    for (int r = 0; r < 4; r++) drive_row1(r, 16'h0100);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      idle1();
      for (int c = 0; c < 4; c++) exp_row[c*16 +: 16] = 16'(16'h0100 + 10*r + c);
      checks++; if (bus1.mem_wr_en !== 1'b1 || bus1.mem_data !== exp_row) begin errors++; $display("FAIL rdy_clear_row %0d: got wr_en %b data %h expected 1 %h", r, bus1.mem_wr_en, bus1.mem_data, exp_row); end
    end
    @(negedge clk);
  endtask

  task automatic test_latency3();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      idle3();
      bus3.matmul_output_valid = 4'hF;
      for (int c = 0; c < 4; c++) bus3.matmul_fsm_output[c*16 +: 16] = 16'(10*r + c);
    end
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      idle3();
      checks++; if (bus3.mem_wr_en !== ((k % 3 == 0) && k < 12)) begin errors++; $display("FAIL lat3_wr_en cycle %0d: got %b expected %b", k, bus3.mem_wr_en, (k % 3 == 0) && k < 12); end
      checks++; if (bus3.stall !== (k < 12)) begin errors++; $display("FAIL lat3_stall cycle %0d: got %b expected %b", k, bus3.stall, k < 12); end
      checks++; if (bus3.wr_output_done !== (k == 12)) begin errors++; $display("FAIL lat3_done cycle %0d: got %b expected %b", k, bus3.wr_output_done, k == 12); end
      if (k < 12) begin
        checks++; if (bus3.mem_addr !== 32'(k / 3)) begin errors++; $display("FAIL lat3_addr cycle %0d: got %h expected %h", k, bus3.mem_addr, k / 3); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    for (int r = 0; r < 4; r++) drive_row1(r, 0);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      idle1();
      checks++; if (bus1.mem_wr_en !== 1'b1 || bus1.mem_addr !== 32'(r)) begin errors++; $display("FAIL midrst_pre_write %0d: got wr_en %b addr %h expected 1 %h", r, bus1.mem_wr_en, bus1.mem_addr, r); end
    end
    rst = 1'b0;
    #1;
    checks++; if ({bus1.stall, bus1.wr_output_rdy, bus1.wr_output_done, bus1.mem_wr_en} !== 4'b0000) begin errors++; $display("FAIL midrst_outs: got %b expected 0000", {bus1.stall, bus1.wr_output_rdy, bus1.wr_output_done, bus1.mem_wr_en}); end
    checks++; if (bus1.mem_addr !== 32'd0 || bus1.mem_data !== 64'd0) begin errors++; $display("FAIL midrst_addr_data: got %h %h expected 0 0", bus1.mem_addr, bus1.mem_data); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (bus1.mem_wr_en !== 1'b0 || bus1.wr_output_done !== 1'b0) begin errors++; $display("FAIL midrst_after cycle %0d: got wr_en %b done %b expected 0 0", k, bus1.mem_wr_en, bus1.wr_output_done); end
    end
  endtask

  initial begin
    test_reset();
    test_skewed();
    test_proxy();
    test_early_done();
    test_overflow();
    test_rdy_clear();
    test_latency3();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
